// File: rtl/lfsr_pkg.sv
// lfsr_pkg: default maximal-length Galois tap masks and the single-step function
package lfsr_pkg;
    localparam logic [2:0]  TAPS_3  = 3'h6;
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [4:0]  TAPS_5  = 5'h1B;
    localparam logic [5:0]  TAPS_6  = 6'h30;
    localparam logic [6:0]  TAPS_7  = 7'h60;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [8:0]  TAPS_9  = 9'h110;
    localparam logic [9:0]  TAPS_10 = 10'h240;
    localparam logic [10:0] TAPS_11 = 11'h500;
    localparam logic [11:0] TAPS_12 = 12'h829;
    localparam logic [12:0] TAPS_13 = 13'h100D;
    localparam logic [13:0] TAPS_14 = 14'h2015;
    localparam logic [14:0] TAPS_15 = 15'h6000;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [16:0] TAPS_17 = 17'h12000;
    localparam logic [17:0] TAPS_18 = 18'h20400;
    localparam logic [18:0] TAPS_19 = 19'h40023;
    localparam logic [19:0] TAPS_20 = 20'h90000;
    localparam logic [20:0] TAPS_21 = 21'h140000;
    localparam logic [21:0] TAPS_22 = 22'h300000;
    localparam logic [22:0] TAPS_23 = 23'h420000;
    localparam logic [23:0] TAPS_24 = 24'hE10000;
    localparam logic [24:0] TAPS_25 = 25'h1200000;
    localparam logic [25:0] TAPS_26 = 26'h2000023;
    localparam logic [26:0] TAPS_27 = 27'h4000013;
    localparam logic [27:0] TAPS_28 = 28'h9000000;
    localparam logic [28:0] TAPS_29 = 29'h14000000;
    localparam logic [29:0] TAPS_30 = 30'h20000029;
    localparam logic [30:0] TAPS_31 = 31'h48000000;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Narrower registers zero-extend into this and truncate the result back
    function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
        return (state >> 1) ^ (state[0] ? taps : 32'd0);
    endfunction
endpackage

// File: rtl/lfsr_gen_step_unit.sv
// lfsr_step_unit: one combinational Galois step; fb is the bit shifted out
module lfsr_step_unit
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next,
    output logic             fb
);
    assign fb   = s[0];
    assign next = WIDTH'(lfsr_step(32'(s), 32'(taps)));
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR with step enable, zero-seed protection and wrap pulse.
// Define LFSR_PERIOD_CNT_EN to add the step counter and the Period output.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_5),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               STEPS = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Enable,
    input  logic [WIDTH-1:0] inState,
    output logic [WIDTH-1:0] RO,
    output logic [STEPS-1:0] SO,
    output logic             Wrap,
    output logic             Lockup
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH:0]   Period
`endif
);
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "lfsr_gen: WIDTH must be 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr_gen: SEED must be non-zero");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $fatal(1, "lfsr_gen: STEPS must be 1..WIDTH");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
        $fatal(1, "lfsr_gen: TAPS MSB must be set");
    end

    logic [WIDTH-1:0] chain [STEPS+1];
    logic [WIDTH-1:0] start;
    logic [STEPS-1:0] hit;
    logic [WIDTH-1:0] load_val;
    logic             wrap_hit;
    logic             ro_zero;

    assign chain[0] = RO;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        lfsr_step_unit #(.WIDTH(WIDTH)) u_step (
            .s    (chain[k]),
            .taps (TAPS),
            .next (chain[k+1]),
            .fb   (SO[k])
        );
        assign hit[k] = chain[k+1] == start;
    end

    assign wrap_hit = |hit;
    assign ro_zero  = ~|RO;
    assign load_val = |inState ? inState : SEED;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RO     <= SEED;
            start  <= SEED;
            Wrap   <= 1'b0;
            Lockup <= 1'b0;
        end else begin
            Wrap   <= 1'b0;
            Lockup <= 1'b0;
            if (Load) begin
                RO     <= load_val;
                start  <= load_val;
                Lockup <= ~|inState;
            end else if (Enable) begin
                RO     <= ro_zero ? SEED : chain[STEPS];
                Lockup <= ro_zero;
                Wrap   <= ~ro_zero & wrap_hit;
            end
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH:0] cnt;
    logic [WIDTH:0] hit_steps;

    // Earliest matching step within the cycle defines the period
    always_comb begin
        hit_steps = '0;
        for (int k = STEPS - 1; k >= 0; k--)
            if (hit[k]) hit_steps = (WIDTH+1)'(k + 1);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt    <= '0;
            Period <= '0;
        end else if (Load) begin
            cnt <= '0;
        end else if (Enable && !ro_zero) begin
            if (wrap_hit) begin
                cnt    <= '0;
                Period <= cnt + hit_steps;
            end else begin
                cnt <= cnt + (WIDTH+1)'(STEPS);
            end
        end
    end
`endif
endmodule
